mavg_stream: RTL and testbench

Parametrised streaming moving-average filter: averages the last 2^LOG2_DEPTH accepted samples of an unsigned WIDTH-bit stream with a valid qualifier. It keeps a circular sample buffer and a running sum, so the cost per sample is one add and one subtract regardless of depth. It is the next-generation datapath averager for sensor/ADC front ends, where samples arrive sporadically rather than every clock.

---
 rtl/mavg_pkg.sv | 24 ++
 rtl/mavg_window.sv | 41 ++++
 rtl/mavg_stream.sv | 58 +++++
 tb/tb_mavg_stream.sv | 162 ++++++++++++++++
 4 files changed

// File: rtl/mavg_pkg.sv
// Shared sizing helpers for the moving-average filter.
// MAVG_ROUND_EN selects round-half-up instead of truncation.
package mavg_pkg;

    localparam int DEPTH_UNIT = 1;

    function automatic int depth_of(input int log2_depth);
        return DEPTH_UNIT << log2_depth;
    endfunction

    // Running sum of DEPTH full-scale samples plus the rounding bias still fits here.
    function automatic int sum_width(input int width, input int log2_depth);
        return width + log2_depth;
    endfunction

    function automatic int rnd_of(input int log2_depth);
`ifdef MAVG_ROUND_EN
        return 1 << (log2_depth - 1);
`else
        return 0;
`endif
    endfunction

endpackage

// File: rtl/mavg_window.sv
// Circular sample window: exposes the entry about to be overwritten and
// tracks how many real samples it holds since the last reset/clear.
module mavg_window
    import mavg_pkg::*;
#(
    parameter int WIDTH      = 4,
    parameter int LOG2_DEPTH = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    output logic [WIDTH-1:0] evict,
    output logic             full
);

    localparam int DEPTH = depth_of(LOG2_DEPTH);

    logic [DEPTH-1:0][WIDTH-1:0] mem;
    logic [LOG2_DEPTH-1:0]       wr_ptr;
    logic [LOG2_DEPTH:0]         fill;

    assign evict = mem[wr_ptr];
    assign full  = (fill == (LOG2_DEPTH+1)'(DEPTH));

    // wr_ptr is exactly LOG2_DEPTH bits, so the increment wraps DEPTH-1 -> 0.
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            mem    <= '0;
            wr_ptr <= '0;
            fill   <= '0;
        end else if (wr_en) begin
            mem[wr_ptr] <= wr_data;
            wr_ptr      <= wr_ptr + 1'b1;
            if (!full)
                fill <= fill + 1'b1;
        end
    end

endmodule

// File: rtl/mavg_stream.sv
// Streaming moving average over the last 2^LOG2_DEPTH accepted samples.
// Define MAVG_ROUND_EN for round-half-up; default build truncates.
module mavg_stream
    import mavg_pkg::*;
#(
    parameter int WIDTH      = 4,
    parameter int LOG2_DEPTH = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    output logic             full
);

    localparam int SW  = sum_width(WIDTH, LOG2_DEPTH);
    localparam int RND = rnd_of(LOG2_DEPTH);

    logic [WIDTH-1:0] evict;
    logic [SW-1:0]    sum;
    logic [SW-1:0]    sum_next;
    logic [SW-1:0]    rounded;

    mavg_window #(
        .WIDTH      (WIDTH),
        .LOG2_DEPTH (LOG2_DEPTH)
    ) u_window (
        .clk     (clk),
        .reset   (reset),
        .clear   (clear),
        .wr_en   (in_valid),
        .wr_data (in_data),
        .evict   (evict),
        .full    (full)
    );

    // Unfilled slots read as zero, so warm-up needs no special casing here.
    assign sum_next = sum + SW'(in_data) - SW'(evict);
    assign rounded  = sum_next + SW'(RND);

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            sum       <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
        end else begin
            out_valid <= in_valid;
            if (in_valid) begin
                sum      <= sum_next;
                out_data <= WIDTH'(rounded >> LOG2_DEPTH);
            end
        end
    end

endmodule

// File: tb/tb_mavg_stream.sv
// Directed + random bench for mavg_stream with a queue-based window model.
module tb_mavg_stream;

    logic       clk = 1'b0;
    logic       reset, clear, in_valid;
    logic [3:0] in_data_a;
    logic [7:0] in_data_b;
    logic       out_valid_a, full_a, out_valid_b, full_b;
    logic [3:0] out_data_a;
    logic [7:0] out_data_b;

    int errors = 0;
    int checks = 0;
    bit chk_en = 1'b0;

`ifdef MAVG_ROUND_EN
    localparam bit ROUND = 1'b1;
`else
    localparam bit ROUND = 1'b0;
`endif

    always #5 clk = ~clk;

    mavg_stream #(.WIDTH(4), .LOG2_DEPTH(2)) dut_a (
        .clk(clk), .reset(reset), .clear(clear), .in_valid(in_valid),
        .in_data(in_data_a), .out_valid(out_valid_a), .out_data(out_data_a), .full(full_a)
    );

    mavg_stream #(.WIDTH(8), .LOG2_DEPTH(6)) dut_b (
        .clk(clk), .reset(reset), .clear(clear), .in_valid(in_valid),
        .in_data(in_data_b), .out_valid(out_valid_b), .out_data(out_data_b), .full(full_b)
    );

    // Model: the window is simply the last DEPTH accepted samples, zero-padded.
    int hist_a[$];
    int hist_b[$];
    int exp_v_a, exp_d_a, exp_f_a, exp_v_b, exp_d_b, exp_f_b;

    function automatic int window_avg(input int q[$], input int depth);
        int s = 0;
        foreach (q[i]) s += q[i];
        if (ROUND) s += depth / 2;
        return s / depth;
    endfunction

    task automatic model_a();
        if (reset || clear) begin
            hist_a.delete(); exp_v_a = 0; exp_d_a = 0; exp_f_a = 0;
        end else if (in_valid) begin
            hist_a.push_back(int'(in_data_a));
            if (hist_a.size() > 4) void'(hist_a.pop_front());
            exp_v_a = 1; exp_d_a = window_avg(hist_a, 4); exp_f_a = (hist_a.size() == 4);
        end else
            exp_v_a = 0;
    endtask

    task automatic model_b();
        if (reset || clear) begin
            hist_b.delete(); exp_v_b = 0; exp_d_b = 0; exp_f_b = 0;
        end else if (in_valid) begin
            hist_b.push_back(int'(in_data_b));
            if (hist_b.size() > 64) void'(hist_b.pop_front());
            exp_v_b = 1; exp_d_b = window_avg(hist_b, 64); exp_f_b = (hist_b.size() == 64);
        end else
            exp_v_b = 0;
    endtask

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            check("a.out_valid", int'(out_valid_a), exp_v_a);
            check("a.out_data",  int'(out_data_a),  exp_d_a);
            check("a.full",      int'(full_a),      exp_f_a);
            check("b.out_valid", int'(out_valid_b), exp_v_b);
            check("b.out_data",  int'(out_data_b),  exp_d_b);
            check("b.full",      int'(full_b),      exp_f_b);
        end
    end

    task automatic cycle(input bit r, input bit c, input bit v, input int da, input int db);
        reset = r; clear = c; in_valid = v;
        in_data_a = 4'(da); in_data_b = 8'(db);
        @(posedge clk);
        model_a();
        model_b();
        chk_en = 1'b1;
        @(negedge clk);
        #1;
    endtask

    int warm_exp[5];

    initial begin
        reset = 1'b1; clear = 1'b0; in_valid = 1'b0; in_data_a = '0; in_data_b = '0;

        // Reset held while a sample is offered: everything stays zero.
        for (int i = 0; i < 2; i++) begin
            cycle(1, 0, 1, 15, 255);
            check("reset.out_valid", int'(out_valid_a), 0);
            check("reset.out_data",  int'(out_data_a),  0);
            check("reset.full",      int'(full_a),      0);
        end

        // Warm-up 15,15,15,15,0.
        if (ROUND) warm_exp = '{4, 8, 11, 15, 11};
        else       warm_exp = '{3, 7, 11, 15, 11};
        for (int i = 0; i < 5; i++) begin
            cycle(0, 0, 1, (i < 4) ? 15 : 0, 200);
            check($sformatf("warm[%0d].data", i), int'(out_data_a), warm_exp[i]);
            check($sformatf("warm[%0d].model", i), exp_d_a, warm_exp[i]);
            if (i == 2) check("warm.full_before", int'(full_a), 0);
            if (i == 3) check("warm.full_rise",   int'(full_a), 1);
        end

        // Gapped input with wrap: 8 must be evicted by the final 4.
        cycle(0, 1, 0, 0, 0);
        cycle(0, 0, 1, 8, 10);
        check("gap.first", int'(out_data_a), 2);
        cycle(0, 0, 0, 9, 0);
        check("gap.idle_valid", int'(out_valid_a), 0);
        check("gap.idle_hold",  int'(out_data_a),  2);
        for (int i = 0; i < 3; i++) begin
            cycle(0, 0, 1, 0, 0);
            cycle(0, 0, 0, 7, 0);
        end
        cycle(0, 0, 1, 4, 0);
        check("gap.evict", int'(out_data_a), 1);
        check("gap.full",  int'(full_a), 1);

        // Clear wins over a simultaneous sample.
        cycle(0, 1, 1, 12, 99);
        check("clear.out_valid", int'(out_valid_a), 0);
        check("clear.out_data",  int'(out_data_a),  0);
        check("clear.full",      int'(full_a),      0);
        cycle(0, 0, 1, 12, 0);
        check("clear.restart", int'(out_data_a), 3);

        // Deep window saturated at full scale.
        cycle(0, 1, 0, 0, 0);
        for (int i = 0; i < 64; i++) cycle(0, 0, 1, 1, 255);
        check("sweep.data", int'(out_data_b), 255);
        check("sweep.full", int'(full_b), 1);

        // Random stream with sporadic valid and occasional clear/reset.
        for (int i = 0; i < 400; i++)
            cycle(($urandom_range(0, 199) == 0), ($urandom_range(0, 59) == 0),
                  ($urandom_range(0, 3) != 0), int'($urandom_range(0, 15)),
                  int'($urandom_range(0, 255)));

        chk_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
